// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
//
// Front end of a UART receiver. It synchronizes the raw serial line, finds the
// start bit, and samples each data bit near the middle of its bit period. Each
// sampled bit is emitted as a one-cycle strobe that a separate downstream
// shift register can use as its shift enable. The sampler only produces
// strobes and status. It does not assemble the received word itself.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//   DATA_BITS     data bits per frame (1..16)
//
// Ports
//   clk           single clock, rising edge
//   i_sclr_n      synchronous active-low reset
//   i_rx          asynchronous serial line, idle high
//   o_bit         sampled data bit, valid while o_bit_vld is high, else holds
//   o_bit_vld     one-cycle strobe per data bit (LSB first)
//   o_clr         one-cycle strobe at start-bit detection
//   o_done        one-cycle strobe at the stop-bit sample
//   o_frame_err   stop bit sampled low, held until the next o_clr
//   o_parity_err  even-parity mismatch, held until the next o_clr
//   o_busy        high whenever the receiver is not idle
//
// Build option
//   UART_RX_PARITY_EN  when defined, one even-parity bit follows the data bits.
//                      When undefined, there is no parity stage and
//                      o_parity_err is tied low.
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic i_sclr_n,
    input  logic i_rx,
    output logic o_bit,
    output logic o_bit_vld,
    output logic o_clr,
    output logic o_done,
    output logic o_frame_err,
    output logic o_parity_err,
    output logic o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic             rxMeta_q, rxSync_q;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
    logic             bit_q, bit_d;
    logic             bitVld_q, bitVld_d;
    logic             clr_q, clr_d;
    logic             done_q, done_d;
    logic             frameErr_q, frameErr_d;
`ifdef UART_RX_PARITY_EN
    logic             parityErr_q, parityErr_d;
    logic             parAcc_q, parAcc_d;
`endif

    // Two-flop synchronizer on the raw line. The flops reset to the idle-high
    // level so that leaving reset can never look like a start bit.
    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= i_rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // State register and registered outputs. Registering every strobe means
    // reset drives all outputs low by the clock edge after it is applied.
    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            state_q     <= IDLE;
            baudCnt_q   <= '0;
            bitIdx_q    <= '0;
            bit_q       <= 1'b0;
            bitVld_q    <= 1'b0;
            clr_q       <= 1'b0;
            done_q      <= 1'b0;
            frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
            parAcc_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            bitIdx_q    <= bitIdx_d;
            bit_q       <= bit_d;
            bitVld_q    <= bitVld_d;
            clr_q       <= clr_d;
            done_q      <= done_d;
            frameErr_q  <= frameErr_d;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= parityErr_d;
            parAcc_q    <= parAcc_d;
`endif
        end
    end

    // Next-state logic. START waits half a bit so that every later sample,
    // taken one full bit period apart, lands near the middle of its bit.
    // A line that is high again at the half-bit point was a glitch, so the
    // receiver drops back to IDLE without reporting anything.
    always_comb begin
        state_d     = state_q;
        baudCnt_d   = baudCnt_q;
        bitIdx_d    = bitIdx_q;
        bit_d       = bit_q;
        bitVld_d    = 1'b0;
        clr_d       = 1'b0;
        done_d      = 1'b0;
        frameErr_d  = frameErr_q;
`ifdef UART_RX_PARITY_EN
        parityErr_d = parityErr_q;
        parAcc_d    = parAcc_q;
`endif

        case (state_q)
            IDLE: begin
                if (!rxSync_q) begin
                    state_d     = START;
                    baudCnt_d   = '0;
                    bitIdx_d    = '0;
                    clr_d       = 1'b1;
                    frameErr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    parityErr_d = 1'b0;
                    parAcc_d    = 1'b0;
`endif
                end
            end

            START: begin
                if (baudCnt_q == HALF_LAST) begin
                    baudCnt_d = '0;
                    state_d   = rxSync_q ? IDLE : DATA;
                end else begin
                    baudCnt_d = baudCnt_q + CNT_ONE;
                end
            end

            DATA: begin
                if (baudCnt_q == FULL_LAST) begin
                    bit_d     = rxSync_q;
                    bitVld_d  = 1'b1;
                    baudCnt_d = '0;
                    bitIdx_d  = bitIdx_q + IDX_ONE;
`ifdef UART_RX_PARITY_EN
                    parAcc_d  = parAcc_q ^ rxSync_q;
`endif
                    if (bitIdx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baudCnt_d = baudCnt_q + CNT_ONE;
                end
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: the data bits and the parity bit together must
            // XOR to zero.
            PARITY: begin
                if (baudCnt_q == FULL_LAST) begin
                    parityErr_d = parAcc_q ^ rxSync_q;
                    baudCnt_d   = '0;
                    state_d     = STOP;
                end else begin
                    baudCnt_d = baudCnt_q + CNT_ONE;
                end
            end
`endif

            // Returning to IDLE at the mid-stop sample gives the receiver the
            // rest of the stop bit to rearm, so back-to-back frames work.
            STOP: begin
                if (baudCnt_q == FULL_LAST) begin
                    done_d     = 1'b1;
                    frameErr_d = ~rxSync_q;
                    baudCnt_d  = '0;
                    state_d    = IDLE;
                end else begin
                    baudCnt_d = baudCnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d   = IDLE;
                baudCnt_d = '0;
                bitIdx_d  = '0;
            end
        endcase
    end

    assign o_bit       = bit_q;
    assign o_bit_vld   = bitVld_q;
    assign o_clr       = clr_q;
    assign o_done      = done_q;
    assign o_frame_err = frameErr_q;
    assign o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parityErr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
//
// Directed and randomized frames for uart_rx_sampler with CLKS_PER_BIT=4 and
// DATA_BITS=8. A monitor records every strobe. A frame-level model records
// what each transmitted frame should produce: data bits LSB first, one done
// per frame, the frame error (stop bit low), and the parity error (XOR of the
// data bits and the parity bit, when the parity stage is compiled in).
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int CPB   = 4;
    localparam int DBITS = 8;

    logic clk;
    logic i_sclr_n;
    logic i_rx;
    logic o_bit, o_bit_vld, o_clr, o_done, o_frame_err, o_parity_err, o_busy;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DBITS)
    ) dut (
        .clk         (clk),
        .i_sclr_n    (i_sclr_n),
        .i_rx        (i_rx),
        .o_bit       (o_bit),
        .o_bit_vld   (o_bit_vld),
        .o_clr       (o_clr),
        .o_done      (o_done),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err),
        .o_busy      (o_busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFails   = 0;

    // Free-running cycle count used to time-stamp monitor events
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor records
    int   vldCnt, doneCnt, clrCnt;
    logic bitQ[$];
    int   cycQ[$];
    logic frameErrQ[$];
    logic parErrQ[$];
    int   lastClrCyc, lastBusyFall;
    logic busyPrev, frameErrPrev, frameErrBeforeClr, frameErrAtClr;

    // Model expectations
    logic expBits[$];
    logic expFrameErr[$];
    logic expParErr[$];

    // Monitor: samples the DUT on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (o_bit_vld) begin
            vldCnt++;
            bitQ.push_back(o_bit);
            cycQ.push_back(cyc);
        end
        if (o_done) begin
            doneCnt++;
            frameErrQ.push_back(o_frame_err);
            parErrQ.push_back(o_parity_err);
        end
        if (o_clr) begin
            clrCnt++;
            lastClrCyc        = cyc;
            frameErrBeforeClr = frameErrPrev;
            frameErrAtClr     = o_frame_err;
        end
        if (busyPrev && !o_busy) lastBusyFall = cyc;
        busyPrev     = o_busy;
        frameErrPrev = o_frame_err;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Inputs change just after the falling edge, after the monitor has sampled
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clearMonitor();
        vldCnt = 0; doneCnt = 0; clrCnt = 0;
        bitQ.delete(); cycQ.delete(); frameErrQ.delete(); parErrQ.delete();
        expBits.delete(); expFrameErr.delete(); expParErr.delete();
        lastClrCyc = -100; lastBusyFall = -1;
        frameErrBeforeClr = 1'b0; frameErrAtClr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Transmit one frame and record what it should produce. A low stop bit
    // is held only to just past the receiver's sample point and then the line
    // is released high, so the error frame cannot be mistaken for a new start.
    task automatic applyStimulus(input logic [DBITS-1:0] data, input logic parityBit,
                                 input logic stopBit);
        i_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DBITS; i++) begin
            i_rx = data[i];
            expBits.push_back(data[i]);
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = parityBit;
        tick(CPB);
        expParErr.push_back((^data) ^ parityBit);
`else
        expParErr.push_back(1'b0);
`endif
        expFrameErr.push_back(~stopBit);
        i_rx = stopBit;
        if (stopBit) begin
            tick(CPB);
        end else begin
            tick(CPB - 1);
            i_rx = 1'b1;
            tick(1);
        end
        i_rx = 1'b1;
    endtask

    task automatic checkScoreboard(input string tag);
        int mism;
        int bad;
        checkOutput({tag, " strobe count"}, bitQ.size(), expBits.size());
        mism = 0;
        for (int i = 0; i < bitQ.size() && i < expBits.size(); i++)
            if (bitQ[i] !== expBits[i]) mism++;
        checkOutput({tag, " bit mismatches"}, mism, 0);
        bad = 0;
        for (int i = 1; i < cycQ.size(); i++)
            if ((i % DBITS) != 0 && (cycQ[i] - cycQ[i-1]) != CPB) bad++;
        checkOutput({tag, " strobe spacing errors"}, bad, 0);
        checkOutput({tag, " done count"}, doneCnt, expFrameErr.size());
        mism = 0;
        for (int i = 0; i < frameErrQ.size() && i < expFrameErr.size(); i++)
            if (frameErrQ[i] !== expFrameErr[i]) mism++;
        checkOutput({tag, " frame_err mismatches"}, mism, 0);
        mism = 0;
        for (int i = 0; i < parErrQ.size() && i < expParErr.size(); i++)
            if (parErrQ[i] !== expParErr[i]) mism++;
        checkOutput({tag, " parity_err mismatches"}, mism, 0);
    endtask

    logic [DBITS-1:0] rnd;
    logic             lineBits[12];
    int               c;

    initial begin
        busyPrev = 1'b0; frameErrPrev = 1'b0;
        clearMonitor();
        i_rx     = 1'b1;
        i_sclr_n = 1'b0;

        // Reset state
        tick(3);
        checkOutput("reset outputs",
                    {25'd0, o_bit, o_bit_vld, o_clr, o_done, o_frame_err, o_parity_err, o_busy},
                    32'd0);
        i_sclr_n = 1'b1;
        tick(4);

        // 0xA5 with a good stop bit
        $display("[TB] frame 0xA5");
        clearMonitor();
        applyStimulus(8'hA5, ^8'hA5, 1'b1);
        tick(6);
        checkScoreboard("a5");
        checkOutput("a5 clr count", clrCnt, 1);
        checkOutput("a5 busy after frame", o_busy, 1'b0);

        // One-cycle glitch in IDLE
        $display("[TB] start-bit glitch");
        clearMonitor();
        i_rx = 1'b0;
        tick(1);
        i_rx = 1'b1;
        tick(10);
        checkOutput("glitch clr count", clrCnt, 1);
        checkOutput("glitch busy drop delay", lastBusyFall - lastClrCyc, 2);
        checkOutput("glitch strobes", vldCnt, 0);
        checkOutput("glitch done", doneCnt, 0);

        // 0x3C with a low stop bit, then a random good frame
        $display("[TB] frame 0x3C with framing error");
        clearMonitor();
        applyStimulus(8'h3C, ^8'h3C, 1'b0);
        tick(10);
        checkOutput("3c frame_err held", o_frame_err, 1'b1);
        rnd = DBITS'($urandom);
        applyStimulus(rnd, ^rnd, 1'b1);
        tick(6);
        checkOutput("3c frame_err before clr", frameErrBeforeClr, 1'b1);
        checkOutput("3c frame_err at clr", frameErrAtClr, 1'b0);
        checkScoreboard("3c+next");

        // Reset after the third data strobe of a frame
        $display("[TB] reset mid-frame");
        clearMonitor();
        rnd = DBITS'($urandom);
        lineBits[0] = 1'b0;
        for (int i = 0; i < DBITS; i++) lineBits[i+1] = rnd[i];
        for (int i = DBITS + 1; i < 12; i++) lineBits[i] = 1'b1;
        c = 0;
        while (c < 11 * CPB && vldCnt < 3) begin
            i_rx = lineBits[c / CPB];
            tick(1);
            c++;
        end
        checkOutput("midreset strobes before reset", vldCnt, 3);
        checkOutput("midreset first bits", {29'd0, bitQ.size() > 2 ? bitQ[2] : 1'bx,
                    bitQ.size() > 1 ? bitQ[1] : 1'bx, bitQ.size() > 0 ? bitQ[0] : 1'bx},
                    {29'd0, rnd[2:0]});
        i_sclr_n = 1'b0;
        i_rx     = 1'b1;
        tick(1);
        checkOutput("midreset outputs",
                    {25'd0, o_bit, o_bit_vld, o_clr, o_done, o_frame_err, o_parity_err, o_busy},
                    32'd0);
        i_sclr_n = 1'b1;
        tick(50);
        checkOutput("midreset no strobes after", vldCnt, 3);
        checkOutput("midreset no done after", doneCnt, 0);
        clearMonitor();
        applyStimulus(8'h5A, ^8'h5A, 1'b1);
        tick(6);
        checkScoreboard("5a after reset");

        // Back-to-back 0x01 and 0xFF
        $display("[TB] back-to-back frames");
        clearMonitor();
        applyStimulus(8'h01, ^8'h01, 1'b1);
        applyStimulus(8'hFF, ^8'hFF, 1'b1);
        tick(6);
        checkScoreboard("b2b");

        // Randomized frames with random idle gaps and occasional bad stop bits
        $display("[TB] random frames");
        clearMonitor();
        for (int f = 0; f < 6; f++) begin
            rnd = DBITS'($urandom);
            applyStimulus(rnd, ^rnd, ($urandom_range(0, 3) != 0));
            tick($urandom_range(1, 6));
        end
        tick(6);
        checkScoreboard("random");

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has odd weight, so parity bit 0 is an error
        $display("[TB] parity frames");
        clearMonitor();
        applyStimulus(8'h07, 1'b0, 1'b1);
        tick(4);
        checkOutput("parity 0x07 p=0", o_parity_err, 1'b1);
        applyStimulus(8'h07, 1'b1, 1'b1);
        tick(4);
        checkOutput("parity 0x07 p=1", o_parity_err, 1'b0);
        checkScoreboard("parity");
`else
        checkOutput("parity_err tied low", o_parity_err, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
